// File: rtl/cam_capture.sv
`timescale 1ns/1ps
// cam_capture: oversampled OV7670-style receiver that packs RGB565 byte pairs into
// sequential RGB332 frame-buffer writes. Define CAM_CAPTURE_TESTPAT_EN for colour bars.
module cam_capture #(
  parameter int H_PIX = 160,
  parameter int V_PIX = 120,
  parameter int AW    = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CAM_pclk,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic [7:0]    CAM_px_data,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_data,
  output logic          mem_we,
  output logic          frame_done,
  output logic          overflow
);

  localparam logic [1:0] WAIT_VS    = 2'd0;
  localparam logic [1:0] WAIT_START = 2'd1;
  localparam logic [1:0] BYTE1      = 2'd2;
  localparam logic [1:0] BYTE2      = 2'd3;

  // One extra address bit so the limit is representable even when H_PIX*V_PIX == 2**AW.
  localparam logic [AW:0] PIX_LIMIT = (AW+1)'(H_PIX * V_PIX);

  function automatic logic [7:0] rgb565_to_rgb332(input logic [5:0] hi, input logic [7:0] lo);
    return {hi, lo[4:3]};
  endfunction

`ifdef CAM_CAPTURE_TESTPAT_EN
  localparam int XW = $clog2(H_PIX) + 1;

  function automatic logic [7:0] bar_color(input logic [XW-1:0] col);
    logic [31:0] bar;
    bar = (32'(col) * 32'd8) / 32'(H_PIX);
    case (bar)
      32'd0:   return 8'hFF;
      32'd1:   return 8'hFC;
      32'd2:   return 8'h1F;
      32'd3:   return 8'h1C;
      32'd4:   return 8'hE3;
      32'd5:   return 8'hE0;
      32'd6:   return 8'h03;
      default: return 8'h00;
    endcase
  endfunction

  logic [XW-1:0] x;
`endif

  logic        pclk_s1, pclk_s2, pclk_s3;
  logic        vsync_s1, vsync_s2, vsync_s3;
  logic        href_s1, href_s2;
  logic [7:0]  data_s1, data_s2;
  logic [1:0]  state;
  logic [5:0]  byte1_hi;
  logic [AW:0] addr_q;

  logic pclk_rise, vs_rise, vs_fall, byte_stb;

  assign pclk_rise = pclk_s2 & ~pclk_s3;
  assign vs_rise   = vsync_s2 & ~vsync_s3;
  assign vs_fall   = ~vsync_s2 & vsync_s3;
  assign byte_stb  = pclk_rise & href_s2;
  assign mem_addr  = addr_q[AW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pclk_s1    <= 1'b0;
      pclk_s2    <= 1'b0;
      pclk_s3    <= 1'b0;
      vsync_s1   <= 1'b0;
      vsync_s2   <= 1'b0;
      vsync_s3   <= 1'b0;
      href_s1    <= 1'b0;
      href_s2    <= 1'b0;
      data_s1    <= 8'h00;
      data_s2    <= 8'h00;
      state      <= WAIT_VS;
      byte1_hi   <= 6'd0;
      addr_q     <= '0;
      mem_data   <= 8'h00;
      mem_we     <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
`ifdef CAM_CAPTURE_TESTPAT_EN
      x          <= '0;
`endif
    end else begin
      // Synchroniser: every camera signal sees the same two-flop delay.
      pclk_s1  <= CAM_pclk;
      pclk_s2  <= pclk_s1;
      pclk_s3  <= pclk_s2;
      vsync_s1 <= CAM_vsync;
      vsync_s2 <= vsync_s1;
      vsync_s3 <= vsync_s2;
      href_s1  <= CAM_href;
      href_s2  <= href_s1;
      data_s1  <= CAM_px_data;
      data_s2  <= data_s1;

      // Capture stage: strobes default low, address trails each write by one cycle.
      mem_we     <= 1'b0;
      frame_done <= 1'b0;
      if (mem_we) addr_q <= addr_q + (AW+1)'(1);
`ifdef CAM_CAPTURE_TESTPAT_EN
      if (!href_s2) x <= '0;
`endif

      case (state)
        WAIT_VS: begin
          if (vsync_s2) state <= WAIT_START;
        end
        WAIT_START: begin
          if (vs_fall) begin
            state    <= BYTE1;
            addr_q   <= '0;
            overflow <= 1'b0;
`ifdef CAM_CAPTURE_TESTPAT_EN
            x        <= '0;
`endif
          end
        end
        BYTE1: begin
          if (vs_rise) begin
            frame_done <= 1'b1;
            state      <= WAIT_START;
          end else if (byte_stb) begin
            byte1_hi <= {data_s2[7:5], data_s2[2:0]};
            state    <= BYTE2;
          end
        end
        BYTE2: begin
          if (byte_stb) begin
            if (addr_q == PIX_LIMIT) begin
              overflow <= 1'b1;
            end else begin
              mem_we <= 1'b1;
`ifdef CAM_CAPTURE_TESTPAT_EN
              mem_data <= bar_color(x);
`else
              mem_data <= rgb565_to_rgb332(byte1_hi, data_s2);
`endif
            end
`ifdef CAM_CAPTURE_TESTPAT_EN
            if (x != '1) x <= x + XW'(1);
`endif
          end
          // A coincident vsync rise still lets the final pixel write above.
          if (vs_rise) begin
            frame_done <= 1'b1;
            state      <= WAIT_START;
          end else if (byte_stb || !href_s2) begin
            state <= BYTE1;
          end
        end
        default: state <= WAIT_VS;
      endcase
    end
  end

endmodule
